memo_table_cam: RTL
===================

// Module: memo_table_cam
// PURPOSE
//  Parametrised associative memoization table, successor to the fixed 8-entry memo table.
//  Lookup key is (start_pc, ctx_hash); a hit returns up to MAX_WRITES register writes and next_pc.
//  Adds registered lookup, insert handshake, replacement, invalidate-by-PC and flush.
//  Sits between the memo unit (lookup/insert) and the fetch redirect / regfile write path.
// PARAMETERS
//  NUM_ENTRIES  8   table depth, >=2, power of two
//  MAX_WRITES   3   register writes carried per entry
//  XLEN         32  PC / data width
//  REGW         5   register index width
//  HASH_W       32  ctx_hash width
// PORTS
//  clk           in   1                   clock, all state on rising edge
//  rst           in   1                   asynchronous reset, active-high
//  lk_valid      in   1                   lookup request this cycle
//  lk_pc         in   XLEN                lookup start_pc
//  lk_hash       in   HASH_W              lookup ctx_hash
//  rsp_valid     out  1                   lookup result valid (1 cycle after lk_valid)
//  rsp_hit       out  1                   lookup hit
//  rsp_wr_mask   out  MAX_WRITES          valid writes (0 on miss)
//  rsp_wr_ids    out  MAX_WRITES*REGW     packed ids, slot k at [k*REGW +: REGW]
//  rsp_wr_vals   out  MAX_WRITES*XLEN     packed values, slot k at [k*XLEN +: XLEN]
//  rsp_next_pc   out  XLEN                bypass target (0 on miss)
//  ins_valid     in   1                   insert request
//  ins_ready     out  1                   insert accepted when ins_valid & ins_ready
//  ins_pc, ins_hash, ins_wr_mask, ins_wr_ids, ins_wr_vals, ins_next_pc  in  as rsp_*  entry fields
//  inv_valid     in   1                   invalidate all entries with start_pc == inv_pc
//  inv_pc        in   XLEN                invalidate key
//  flush         in   1                   clear whole table
//  occupancy     out  $clog2(NUM_ENTRIES)+1  number of valid entries
// BEHAVIOUR
//  - Reset: all valid bits 0, victim ptr 0, rsp_* 0, occupancy 0; payload RAM not reset.
//  - Lookup: compare all valid entries in cycle N; registered result at N+1. Multiple matches
//    (illegal) -> lowest index wins. On miss, rsp_wr_mask/ids/vals/next_pc are all 0.
//  - Lookup in same cycle as insert/inv/flush sees pre-edge contents (old data).
//  - ins_ready = ~flush & ~inv_valid (combinational). Insert commits at the accepting edge.
//  - Insert slot: existing entry with equal (pc,hash) -> overwrite in place; else lowest invalid;
//    else entry at victim ptr, ptr += 1 mod NUM_ENTRIES (wraps). Ptr moves only on evicting insert.
//  - wr_mask stored as given; wr_ids[k]==0 with mask bit set is stored; consumer ignores x0.
//  - inv_valid: clears every valid entry whose start_pc == inv_pc, any hash; 1-cycle effect.
//  - flush: clears all valid bits and victim ptr at next edge; priority flush > inv > insert.
//  - occupancy updates the cycle after the change; saturates at NUM_ENTRIES by construction.
//  - Reset asserted mid-operation: pending rsp discarded, state as reset, no partial insert.
// CONFIGURATION
//  MEMO_TABLE_STATS_EN defined: adds outputs stat_hits, stat_misses, stat_evicts (32 b each),
//   saturating at 2^32-1, cleared by rst and flush; counted when rsp_valid / evicting insert.
//  Not defined: ports absent, no counter logic.
// TESTING
//  1. Reset, lookup pc=0x100 hash=0xA5 -> next cycle rsp_valid=1, rsp_hit=0, rsp_next_pc=0.
//  2. Insert (0x100,0xA5,mask=3'b011,ids{5,6},vals{7,9},next=0x140), lookup -> hit, mask 011, next 0x140.
//  3. Fill 8 entries, insert 9th -> entry 0 evicted, lookup of entry-0 key misses, occupancy=8, ptr=1.
//  4. Insert existing key with new next=0x200 -> occupancy unchanged, lookup returns 0x200.
//  5. Two entries pc=0x300 (hash 1,2); inv_valid pc=0x300 -> both miss, others still hit.
//  6. flush with ins_valid same cycle -> ins_ready=0, occupancy=0 next cycle; same-cycle lookup hits old.

Source files
------------

// File: rtl/memo_table_cam_if.sv
// Bundle between the memo unit and memo_table_cam: lookup, response, insert, invalidate and flush.
// The master modport is the memo unit side; the slave modport is the table.
interface memo_table_cam_if #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned MAX_WRITES  = 3,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned REGW        = 5,
    parameter int unsigned HASH_W      = 32
);
    localparam int unsigned OCC_W = $clog2(NUM_ENTRIES) + 1;

    logic                         lk_valid;
    logic [XLEN-1:0]              lk_pc;
    logic [HASH_W-1:0]            lk_hash;

    logic                         rsp_valid;
    logic                         rsp_hit;
    logic [MAX_WRITES-1:0]        rsp_wr_mask;
    logic [MAX_WRITES*REGW-1:0]   rsp_wr_ids;
    logic [MAX_WRITES*XLEN-1:0]   rsp_wr_vals;
    logic [XLEN-1:0]              rsp_next_pc;

    logic                         ins_valid;
    logic                         ins_ready;
    logic [XLEN-1:0]              ins_pc;
    logic [HASH_W-1:0]            ins_hash;
    logic [MAX_WRITES-1:0]        ins_wr_mask;
    logic [MAX_WRITES*REGW-1:0]   ins_wr_ids;
    logic [MAX_WRITES*XLEN-1:0]   ins_wr_vals;
    logic [XLEN-1:0]              ins_next_pc;

    logic                         inv_valid;
    logic [XLEN-1:0]              inv_pc;
    logic                         flush;

    logic [OCC_W-1:0]             occupancy;

    modport master (
        output lk_valid, lk_pc, lk_hash,
        input  rsp_valid, rsp_hit, rsp_wr_mask, rsp_wr_ids, rsp_wr_vals, rsp_next_pc,
        output ins_valid, ins_pc, ins_hash, ins_wr_mask, ins_wr_ids, ins_wr_vals, ins_next_pc,
        input  ins_ready,
        output inv_valid, inv_pc, flush,
        input  occupancy
    );

    modport slave (
        input  lk_valid, lk_pc, lk_hash,
        output rsp_valid, rsp_hit, rsp_wr_mask, rsp_wr_ids, rsp_wr_vals, rsp_next_pc,
        input  ins_valid, ins_pc, ins_hash, ins_wr_mask, ins_wr_ids, ins_wr_vals, ins_next_pc,
        output ins_ready,
        input  inv_valid, inv_pc, flush,
        output occupancy
    );
endinterface

// File: rtl/memo_table_cam.sv
// Associative memoization table keyed by (start_pc, ctx_hash) with registered lookup, insert,
// round-robin eviction, invalidate-by-PC and flush. Define MEMO_TABLE_STATS_EN for hit/miss/evict counters.
module memo_table_cam #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned MAX_WRITES  = 3,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned REGW        = 5,
    parameter int unsigned HASH_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    memo_table_cam_if.slave       bus
`ifdef MEMO_TABLE_STATS_EN
    ,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses,
    output logic [31:0]           stat_evicts
`endif
);
    localparam int unsigned IDX_W  = $clog2(NUM_ENTRIES);
    localparam int unsigned OCC_W  = IDX_W + 1;
    localparam int unsigned IDS_W  = MAX_WRITES * REGW;
    localparam int unsigned VALS_W = MAX_WRITES * XLEN;

    // Payload storage, deliberately not reset; valid_q alone qualifies it.
    logic [XLEN-1:0]       mem_pc   [NUM_ENTRIES];
    logic [HASH_W-1:0]     mem_hash [NUM_ENTRIES];
    logic [MAX_WRITES-1:0] mem_mask [NUM_ENTRIES];
    logic [IDS_W-1:0]      mem_ids  [NUM_ENTRIES];
    logic [VALS_W-1:0]     mem_vals [NUM_ENTRIES];
    logic [XLEN-1:0]       mem_next [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [IDX_W-1:0]       victim_q, victim_d;
    logic [OCC_W-1:0]       occ_q, occ_d;

    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_hit_q, rsp_hit_d;
    logic [MAX_WRITES-1:0]  rsp_mask_q, rsp_mask_d;
    logic [IDS_W-1:0]       rsp_ids_q, rsp_ids_d;
    logic [VALS_W-1:0]      rsp_vals_q, rsp_vals_d;
    logic [XLEN-1:0]        rsp_next_q, rsp_next_d;

    logic             lk_hit;
    logic [IDX_W-1:0] lk_idx;
    logic             same_hit, free_hit;
    logic [IDX_W-1:0] same_idx, free_idx, ins_slot;
    logic             ins_ready, ins_fire, ins_evict;

    // Lookup CAM: lowest matching index wins if duplicates ever exist.
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!lk_hit && valid_q[i] && mem_pc[i] == bus.lk_pc && mem_hash[i] == bus.lk_hash) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        rsp_valid_d = bus.lk_valid;
        rsp_hit_d   = bus.lk_valid & lk_hit;
        rsp_mask_d  = '0;
        rsp_ids_d   = '0;
        rsp_vals_d  = '0;
        rsp_next_d  = '0;
        if (bus.lk_valid && lk_hit) begin
            rsp_mask_d = mem_mask[lk_idx];
            rsp_ids_d  = mem_ids[lk_idx];
            rsp_vals_d = mem_vals[lk_idx];
            rsp_next_d = mem_next[lk_idx];
        end
    end

    // Insert slot choice: same key in place, else lowest free, else victim pointer.
    always_comb begin
        same_hit = 1'b0;
        same_idx = '0;
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!same_hit && valid_q[i] && mem_pc[i] == bus.ins_pc &&
                mem_hash[i] == bus.ins_hash) begin
                same_hit = 1'b1;
                same_idx = IDX_W'(i);
            end
            if (!free_hit && !valid_q[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign ins_ready = ~bus.flush & ~bus.inv_valid;
    assign ins_fire  = bus.ins_valid & ins_ready;
    assign ins_evict = ins_fire & ~same_hit & ~free_hit;
    assign ins_slot  = same_hit ? same_idx : (free_hit ? free_idx : victim_q);

    // Flush outranks invalidate; insert is already blocked by ins_ready when either is active.
    always_comb begin
        valid_d  = valid_q;
        victim_d = victim_q;
        if (bus.flush) begin
            valid_d  = '0;
            victim_d = '0;
        end else if (bus.inv_valid) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (valid_q[i] && mem_pc[i] == bus.inv_pc) begin
                    valid_d[i] = 1'b0;
                end
            end
        end else if (ins_fire) begin
            valid_d[ins_slot] = 1'b1;
            if (ins_evict) begin
                victim_d = victim_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            victim_q    <= '0;
            occ_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_mask_q  <= '0;
            rsp_ids_q   <= '0;
            rsp_vals_q  <= '0;
            rsp_next_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            victim_q    <= victim_d;
            occ_q       <= occ_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_mask_q  <= rsp_mask_d;
            rsp_ids_q   <= rsp_ids_d;
            rsp_vals_q  <= rsp_vals_d;
            rsp_next_q  <= rsp_next_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ins_fire && !rst) begin
            mem_pc[ins_slot]   <= bus.ins_pc;
            mem_hash[ins_slot] <= bus.ins_hash;
            mem_mask[ins_slot] <= bus.ins_wr_mask;
            mem_ids[ins_slot]  <= bus.ins_wr_ids;
            mem_vals[ins_slot] <= bus.ins_wr_vals;
            mem_next[ins_slot] <= bus.ins_next_pc;
        end
    end

    assign bus.ins_ready   = ins_ready;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_hit     = rsp_hit_q;
    assign bus.rsp_wr_mask = rsp_mask_q;
    assign bus.rsp_wr_ids  = rsp_ids_q;
    assign bus.rsp_wr_vals = rsp_vals_q;
    assign bus.rsp_next_pc = rsp_next_q;
    assign bus.occupancy   = occ_q;

`ifdef MEMO_TABLE_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_misses_q, stat_misses_d;
    logic [31:0] stat_evicts_q, stat_evicts_d;

    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        stat_evicts_d = stat_evicts_q;
        if (bus.flush) begin
            stat_hits_d   = '0;
            stat_misses_d = '0;
            stat_evicts_d = '0;
        end else begin
            if (bus.lk_valid && lk_hit && stat_hits_q != '1) begin
                stat_hits_d = stat_hits_q + 32'd1;
            end
            if (bus.lk_valid && !lk_hit && stat_misses_q != '1) begin
                stat_misses_d = stat_misses_q + 32'd1;
            end
            if (ins_evict && stat_evicts_q != '1) begin
                stat_evicts_d = stat_evicts_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
            stat_evicts_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
            stat_evicts_q <= stat_evicts_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
    assign stat_evicts = stat_evicts_q;
`endif
endmodule
